// File: rtl/multu_hilo_if.sv
// Command/read bus between the ALU control decoder and the MULTU/HI-LO unit.
// The master issues commands and reads results; the slave is the multiplier.
interface multu_hilo_if #(
    parameter int unsigned WIDTH = 32
);
    logic [5:0]       SignaltoMULTU;
    logic [1:0]       SelHilo;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic [WIDTH-1:0] HiLoOut;
    logic             busy;
    logic             done;

    modport master (
        output SignaltoMULTU,
        output SelHilo,
        output dataA,
        output dataB,
        input  HiLoOut,
        input  busy,
        input  done
    );

    modport slave (
        input  SignaltoMULTU,
        input  SelHilo,
        input  dataA,
        input  dataB,
        output HiLoOut,
        output busy,
        output done
    );
endinterface

// File: rtl/multu_hilo.sv
// Sequential unsigned WIDTH x WIDTH shift-add multiplier with a HI/LO result pair.
// One partial product per cycle; HI/LO are only written when a multiply completes.
module multu_hilo #(
    parameter int unsigned WIDTH     = 32,
    parameter logic [5:0]  CMD_MULTU = 6'b011001
) (
    input logic          clk,
    input logic          rst_n,
    multu_hilo_if.slave  bus
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               req_prev_q, req_prev_d;

    logic             req;
    logic             start;
    logic [WIDTH:0]   sum;

    assign req   = (bus.SignaltoMULTU == CMD_MULTU);
    assign start = req & ~req_prev_q;

    // The extra adder bit carries into the top of the product, so the result is exact.
    assign sum = prod_q[0] ? ({1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q})
                           : {1'b0, prod_q[2*WIDTH-1:WIDTH]};

    always_comb begin
        state_d    = state_q;
        prod_d     = prod_q;
        mcand_d    = mcand_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        req_prev_d = req;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mcand_d = bus.dataA;
                    prod_d  = {{WIDTH{1'b0}}, bus.dataB};
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                prod_d = {sum, prod_q[WIDTH-1:1]};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                hi_d    = prod_q[2*WIDTH-1:WIDTH];
                lo_d    = prod_q[WIDTH-1:0];
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            prod_q     <= '0;
            mcand_q    <= '0;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            req_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            prod_q     <= prod_d;
            mcand_q    <= mcand_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            req_prev_q <= req_prev_d;
        end
    end

    // Reads are not interlocked against a running multiply; they see the last result.
    always_comb begin
        case (bus.SelHilo)
            2'b01:   bus.HiLoOut = hi_q;
            2'b10:   bus.HiLoOut = lo_q;
            default: bus.HiLoOut = '0;
        endcase
    end

    assign bus.busy = (state_q != StIdle);
    assign bus.done = done_q;
endmodule

// File: doc/multu_hilo.md
Name: multu_hilo

Overview:
Sequential unsigned 32x32 multiplier with an integrated HI/LO result register pair. It sits on the datapath side of the ALU control decoder. It responds to the decoder's SignaltoMULTU command code to start a MULTU, and to the SelHilo select to return HI (MFHI) or LO (MFLO). It uses a shift-add algorithm at one partial product per cycle, and commits the 64-bit product to HI/LO on completion.

Parameters:
WIDTH, 32, operand width; product is 2*WIDTH; the step counter runs WIDTH cycles.
CMD_MULTU, 6'b011001, SignaltoMULTU code that requests a multiply.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
SignaltoMULTU  input  6  command from the ALU control decoder; CMD_MULTU = start request; any other value = no request.
SelHilo  input  2  read select: 2'b01 = HI, 2'b10 = LO, 2'b00/2'b11 = none.
dataA  input  WIDTH  multiplicand (rs).
dataB  input  WIDTH  multiplier (rt).
HiLoOut  output  WIDTH  combinational read of the HI/LO registers per SelHilo.
busy  output  1  high while a multiply is in progress (state != IDLE).
done  output  1  registered one-cycle pulse when HI/LO have just been updated.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE; HI=0, LO=0; product, multiplicand and counter = 0; done=0; start-edge register=0.
  - Reset mid-operation aborts the multiply: no HI/LO update, no done pulse.
- Start detection:
  - req = (SignaltoMULTU==CMD_MULTU). A registered copy req_d updates every cycle.
  - start = req & ~req_d (rising edge). The decoder holds the code while Funct is stable, so a held request starts exactly one multiply.
- States: IDLE, RUN, DONE.
  - IDLE: on start, latch mcand<=dataA and prod<={WIDTH'b0, dataB}, set cnt<=0, go to RUN. Otherwise hold.
  - RUN: each cycle, if prod[0]=1 then {carry,upper} = prod[2W-1:W] + mcand (WIDTH+1 bits); else {carry,upper} = {0, prod[2W-1:W]}. Then prod <= {carry, upper, prod[W-1:1]} (shift right by 1). cnt<=cnt+1. When cnt==WIDTH-1, go to DONE.
  - DONE: HI<=prod[2W-1:W], LO<=prod[W-1:0], done<=1, go to IDLE.
- done is 0 in every cycle except the one following the DONE edge.
- Latency (start sampled at edge 0):
  - Edges 1..WIDTH perform the WIDTH steps.
  - Edge WIDTH+1 commits HI/LO and asserts done.
  - busy is high from after edge 0 through edge WIDTH+1.
  - Earliest next start is sampled at edge WIDTH+2.
- Start while busy (RUN or DONE) is ignored. It is not queued. req_d still tracks, so a request held over the end of a multiply does not retrigger.
- dataA/dataB are sampled only at the start edge; changes during RUN have no effect.
- HiLoOut: SelHilo=01 gives HI, 10 gives LO, 00/11 give 0.
  - Purely combinational, zero latency.
  - Reads during busy return the previous HI/LO (stale by design; no interlock).
- Carry: the adder is WIDTH+1 bits and the carry shifts into prod[2W-1], so the full 64-bit unsigned result is exact. There is no overflow condition.
- SignaltoMULTU values other than CMD_MULTU (including 6'b111111 and 0) are no-ops.

Test Plan:
- Reset, then dataA=3, dataB=5, pulse CMD_MULTU for 1 cycle -> busy for 33 cycles; done pulses once at cycle 33; SelHilo=01 gives 0x00000000; SelHilo=10 gives 0x0000000F.
- dataA=0xFFFFFFFF, dataB=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 (carry path exercised every step).
- After the 3x5 result, start 0x00010000 x 0x00010000 and read LO at cycle 10 -> LO reads 0x0000000F (stale). After done: HI=0x00000001, LO=0x00000000.
- Hold SignaltoMULTU=CMD_MULTU for 80 cycles with dataA=7, dataB=6 -> exactly one done pulse; LO=42; busy low from cycle 34 onward.
- Start 0x12345678 x 0x9ABCDEF0, assert rst_n=0 at cycle 10 -> busy=0, HI=LO=0, no done pulse. A subsequent start with the same operands -> HI=0x0B00EA4E, LO=0x242D2080.
- SelHilo=11 and 00 with HI/LO nonzero -> HiLoOut=0. Change dataA/dataB during RUN -> result unchanged.
